// File: rtl/instr_fetch.sv
// Instruction fetch: owns the PC, reads the combinational instruction LUT,
// issues instructions, resolves branches and halts on the done opcode.
// Optional issued-instruction counter enabled by defining ISSUE_COUNT_EN.
module instr_fetch #(
  parameter int PC_W   = 9,
  parameter int INST_W = 20,
  parameter int CNT_W  = 16
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              start,
  input  logic [PC_W-1:0]   start_addr,
  input  logic              stall,
  input  logic              flag_eq,
  input  logic              flag_lt,
  input  logic              flag_gt,
  output logic [PC_W-1:0]   iptr,
  input  logic [INST_W-1:0] inst,
  output logic [INST_W-1:0] inst_out,
  output logic              inst_valid,
  output logic              done,
  output logic [CNT_W-1:0]  issue_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  localparam logic [4:0] OP_BE   = 5'b00111;
  localparam logic [4:0] OP_BL   = 5'b01000;
  localparam logic [4:0] OP_BG   = 5'b01001;
  localparam logic [4:0] OP_BA   = 5'b01010;
  localparam logic [4:0] OP_DONE = 5'b01110;

  state_t          state;
  logic [PC_W-1:0] pc;
  logic [4:0]      op;
  logic            is_done;
  logic            taken;
  logic [PC_W-1:0] boff;
  logic [PC_W-1:0] next_pc;
  logic            launch;

  assign op       = inst[19:15];
  assign is_done  = (op == OP_DONE);
  assign iptr     = pc;
  assign inst_out = inst;

  assign inst_valid = (state == RUN) && !stall && !is_done;
  assign launch     = ((state == IDLE) || (state == HALT)) && start;

  // 15-bit offset is sign-extended (or truncated) to the PC width; the add wraps mod 2^PC_W
  assign boff = PC_W'($signed(inst[14:0]));

  always_comb begin
    taken = 1'b0;
    unique case (op)
      OP_BE:   taken = flag_eq;
      OP_BL:   taken = flag_lt;
      OP_BG:   taken = flag_gt;
      OP_BA:   taken = 1'b1;
      default: taken = 1'b0;
    endcase
    next_pc = taken ? (pc + boff) : (pc + PC_W'(1));
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state <= IDLE;
      pc    <= '0;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            pc    <= start_addr;
            state <= RUN;
          end
        end
        RUN: begin
          if (!stall) begin
            if (is_done) begin
              state <= HALT;
              done  <= 1'b1;
            end else begin
              pc <= next_pc;
            end
          end
        end
        HALT: begin
          if (start) begin
            pc    <= start_addr;
            done  <= 1'b0;
            state <= RUN;
          end
        end
        default: begin
          state <= IDLE;
          done  <= 1'b0;
        end
      endcase
    end
  end

`ifdef ISSUE_COUNT_EN
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      cnt <= '0;
    end else if (launch) begin
      cnt <= '0;
    end else if (inst_valid && (cnt != '1)) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign issue_cnt = cnt;
`else
  logic unused_launch;
  assign unused_launch = launch;
  assign issue_cnt     = '0;
`endif

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Reader side of the instruction LUT: owns the program counter, drives `iptr` and takes back the combinational 20-bit `inst`.
- Issues each instruction to execute with a valid flag.
- Resolves branches from condition flags supplied by execute; halts on the done opcode.
- Sits between the top-level start/done handshake and the decode/execute datapath.

Parameters:
- PC_W, 9, width of program counter / `iptr`.
- INST_W, 20, instruction width. Fields: op=[19:15], rd=[14:10], in_b=[9:5], in_a=[4:0]; branch offset = [14:0].
- CNT_W, 16, width of the issued-instruction counter (optional feature).

Ports:
- Clk  input  1  clock
- Reset_n  input  1  asynchronous active-low reset
- start  input  1  level/pulse; begins execution at `start_addr`
- start_addr  input  PC_W  program entry point
- stall  input  1  execute not ready; hold PC, issue nothing
- flag_eq  input  1  last compare: a==b (valid in the cycle a branch is presented)
- flag_lt  input  1  last compare: a<b
- flag_gt  input  1  last compare: a>b
- iptr  output  PC_W  address to instruction LUT (= PC register)
- inst  input  INST_W  instruction from LUT, combinational from `iptr`
- inst_out  output  INST_W  instruction issued to decode
- inst_valid  output  1  `inst_out` valid this cycle
- done  output  1  program halted
- issue_cnt  output  CNT_W  instructions issued (optional feature)

Behaviour:
- States: IDLE, RUN, HALT (2-bit register). Reset_n low (async) -> IDLE, pc=0, done=0, issue_cnt=0.
- Reset asserted mid-RUN aborts immediately; no further issue.
- `iptr` = pc at all times. `inst_out` = `inst` (pass-through).
- `inst_valid` = (state==RUN) & ~stall & (op != 01110). Combinational, so 0 in reset/IDLE/HALT.
- IDLE: start=1 -> pc<=start_addr, RUN next cycle. First instruction is issued the cycle after start. done=0.
- RUN, stall=1: pc, state and counter hold.
- RUN, stall=0, by op:
  - 01110 (done): state<=HALT, pc holds, nothing issued.
  - 00111 be: taken if flag_eq.
  - 01000 bl: taken if flag_lt.
  - 01001 bg: taken if flag_gt.
  - 01010 ba: always taken.
  - Taken: pc <= pc + sext15(inst[14:0]), truncated to PC_W (mod 2^PC_W). Not taken: pc <= pc+1.
  - All other ops: pc <= pc+1.
- Branch instructions are themselves issued (`inst_valid`=1) so execute can retire them. Zero-bubble redirect, since the LUT is combinational.
- Wrap: pc=2^PC_W-1 with sequential advance -> 0. Negative offsets wrap modulo 2^PC_W.
- Simultaneous flags: each branch looks only at its own flag. Flag values are irrelevant for non-branch ops.
- start while RUN: ignored.
- HALT: done=1 (registered, asserted the cycle after the done op). Stays until start=1 -> pc<=start_addr, done<=0, RUN.
- Done op while stall=1: not acted on until stall drops.

Optional Feature:
- Macro ISSUE_COUNT_EN.
- Defined: `issue_cnt` increments by 1 on every cycle with `inst_valid`=1. Saturates at 2^CNT_W-1. Cleared on reset and on each start from IDLE/HALT.
- Undefined: no counter register; `issue_cnt` tied to 0.

Test Plan:
- Reset, start=1, start_addr=1, program {ld,ld,done} at 1..3 -> `iptr` sequence 1,2,3; inst_valid high 2 cycles; done=1 on the cycle after pc=3; `iptr` holds 3.
- pc=16, inst=0x47FF3 (bl -13), flag_lt=1 -> next `iptr`=3. Same with flag_lt=0 -> next `iptr`=17.
- pc=5, inst=0x38004 (be +4), flag_eq=1, flag_gt=1 -> `iptr`=9. inst=0x48004 (bg +4) at pc=17, flag_gt=1 -> 21. inst=0x50002 (ba +2) -> pc+2 regardless of flags.
- stall=1 for 3 cycles at pc=7 -> `iptr` stays 7, inst_valid=0, issue_cnt unchanged; release -> 8.
- pc=511, non-branch op -> `iptr`=0. pc=2, ba with offset 0x7FFC (-4) -> `iptr`=510.
- Reset_n pulsed low mid-RUN at pc=40 -> immediately `iptr`=0, inst_valid=0, done=0, IDLE. With ISSUE_COUNT_EN, 10 issued instrs then done -> issue_cnt=10; restart clears it to 0.
